// File: rtl/keycode_to_ps2_scancode.sv
// PS/2 Set-2 scancode encoder: one key code in, 0-8 scancode bytes out.
// Handles make/break, E0-extended keys and the fixed 8-byte Pause sequence.
//
// Ports:
//   clk         system clock
//   reset       asynchronous reset, active-high
//   keycode_i   [7] break flag, [6:0] key number
//   kcvalid_i   key code valid
//   kcready_o   encoder idle and able to take a key code
//   scancode_o  scancode byte
//   scvalid_o   scancode byte valid
//   scready_i   downstream takes scancode_o
//   unmapped_o  one-cycle pulse: accepted key has no scancode
module keycode_to_ps2_scancode (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] keycode_i,
  input  logic       kcvalid_i,
  output logic       kcready_o,
  output logic [7:0] scancode_o,
  output logic       scvalid_o,
  input  logic       scready_i,
  output logic       unmapped_o
);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    SEND_E0,
    SEND_F0,
    SEND_CODE,
    PAUSE
  } state_t;

  localparam logic [6:0] K_PAUSE = 7'd126;

  // lookup entry tags: {hit, ext}
  localparam logic [1:0] B = 2'b10;
  localparam logic [1:0] E = 2'b11;

  state_t     state_q, state_d;
  logic [6:0] key_q, key_d;
  logic       brk_q, brk_d;
  logic [7:0] code_q, code_d;
  logic [2:0] pidx_q, pidx_d;
  logic [7:0] sc_d;
  logic       scv_d;
  logic       rdy_d;
  logic       unm_d;
  logic       hs;

  // {hit, ext, code}
  logic [9:0] lk;

  always_comb begin
    lk = 10'h000;
    case (key_q)
      7'd1:   lk = {B, 8'h0E};
      7'd2:   lk = {B, 8'h16};
      7'd3:   lk = {B, 8'h1E};
      7'd4:   lk = {B, 8'h26};
      7'd5:   lk = {B, 8'h25};
      7'd6:   lk = {B, 8'h2E};
      7'd7:   lk = {B, 8'h36};
      7'd8:   lk = {B, 8'h3D};
      7'd9:   lk = {B, 8'h3E};
      7'd10:  lk = {B, 8'h46};
      7'd11:  lk = {B, 8'h45};
      7'd12:  lk = {B, 8'h4E};
      7'd13:  lk = {B, 8'h55};
      7'd15:  lk = {B, 8'h66};
      7'd16:  lk = {B, 8'h0D};
      7'd17:  lk = {B, 8'h15};
      7'd18:  lk = {B, 8'h1D};
      7'd19:  lk = {B, 8'h24};
      7'd20:  lk = {B, 8'h2D};
      7'd21:  lk = {B, 8'h2C};
      7'd22:  lk = {B, 8'h35};
      7'd23:  lk = {B, 8'h3C};
      7'd24:  lk = {B, 8'h43};
      7'd25:  lk = {B, 8'h44};
      7'd26:  lk = {B, 8'h4D};
      7'd27:  lk = {B, 8'h54};
      7'd28:  lk = {B, 8'h5B};
      7'd29:  lk = {B, 8'h5D};
      7'd30:  lk = {B, 8'h58};
      7'd31:  lk = {B, 8'h1C};
      7'd32:  lk = {B, 8'h1B};
      7'd33:  lk = {B, 8'h23};
      7'd34:  lk = {B, 8'h2B};
      7'd35:  lk = {B, 8'h34};
      7'd36:  lk = {B, 8'h33};
      7'd37:  lk = {B, 8'h3B};
      7'd38:  lk = {B, 8'h42};
      7'd39:  lk = {B, 8'h4B};
      7'd40:  lk = {B, 8'h4C};
      7'd41:  lk = {B, 8'h52};
      7'd43:  lk = {B, 8'h5A};
      7'd44:  lk = {B, 8'h12};
      7'd45:  lk = {B, 8'h61};
      7'd46:  lk = {B, 8'h1A};
      7'd47:  lk = {B, 8'h22};
      7'd48:  lk = {B, 8'h21};
      7'd49:  lk = {B, 8'h2A};
      7'd50:  lk = {B, 8'h32};
      7'd51:  lk = {B, 8'h31};
      7'd52:  lk = {B, 8'h3A};
      7'd53:  lk = {B, 8'h41};
      7'd54:  lk = {B, 8'h49};
      7'd55:  lk = {B, 8'h4A};
      7'd57:  lk = {B, 8'h59};
      7'd58:  lk = {B, 8'h14};
      7'd59:  lk = {E, 8'h1F};
      7'd60:  lk = {B, 8'h11};
      7'd61:  lk = {B, 8'h29};
      7'd62:  lk = {E, 8'h11};
      7'd63:  lk = {E, 8'h27};
      7'd64:  lk = {E, 8'h14};
      7'd65:  lk = {E, 8'h2F};
      7'd75:  lk = {E, 8'h70};
      7'd76:  lk = {E, 8'h71};
      7'd79:  lk = {E, 8'h6B};
      7'd80:  lk = {E, 8'h6C};
      7'd81:  lk = {E, 8'h69};
      7'd83:  lk = {E, 8'h75};
      7'd84:  lk = {E, 8'h72};
      7'd85:  lk = {E, 8'h7D};
      7'd86:  lk = {E, 8'h7A};
      7'd89:  lk = {E, 8'h74};
      7'd90:  lk = {B, 8'h77};
      7'd91:  lk = {B, 8'h6C};
      7'd92:  lk = {B, 8'h6B};
      7'd93:  lk = {B, 8'h69};
      7'd95:  lk = {E, 8'h4A};
      7'd96:  lk = {B, 8'h75};
      7'd97:  lk = {B, 8'h73};
      7'd98:  lk = {B, 8'h72};
      7'd99:  lk = {B, 8'h70};
      7'd100: lk = {B, 8'h7C};
      7'd101: lk = {B, 8'h7D};
      7'd102: lk = {B, 8'h74};
      7'd103: lk = {B, 8'h7A};
      7'd104: lk = {B, 8'h71};
      7'd105: lk = {B, 8'h7B};
      7'd106: lk = {B, 8'h79};
      7'd108: lk = {E, 8'h5A};
      7'd110: lk = {B, 8'h76};
      7'd112: lk = {B, 8'h05};
      7'd113: lk = {B, 8'h06};
      7'd114: lk = {B, 8'h04};
      7'd115: lk = {B, 8'h0C};
      7'd116: lk = {B, 8'h03};
      7'd117: lk = {B, 8'h0B};
      7'd118: lk = {B, 8'h83};
      7'd119: lk = {B, 8'h0A};
      7'd120: lk = {B, 8'h01};
      7'd121: lk = {B, 8'h09};
      7'd122: lk = {B, 8'h78};
      7'd123: lk = {B, 8'h07};
      7'd124: lk = {E, 8'h7C};
      7'd125: lk = {B, 8'h7E};
      default: lk = 10'h000;
    endcase
  end

  function automatic logic [7:0] pause_byte(
    input logic [2:0] i
  );
    logic [7:0] b;
    case (i)
      3'd0: b = 8'hE1;
      3'd1: b = 8'h14;
      3'd2: b = 8'h77;
      3'd3: b = 8'hE1;
      3'd4: b = 8'hF0;
      3'd5: b = 8'h14;
      3'd6: b = 8'hF0;
      3'd7: b = 8'h77;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign hs = scvalid_o & scready_i;

  // Output registers are computed one cycle ahead so
  // every output comes straight from a flop.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    brk_d   = brk_q;
    code_d  = code_q;
    pidx_d  = pidx_q;
    sc_d    = scancode_o;
    scv_d   = scvalid_o;
    rdy_d   = 1'b0;
    unm_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        rdy_d = 1'b1;
        if (kcvalid_i & kcready_o) begin
          key_d   = keycode_i[6:0];
          brk_d   = keycode_i[7];
          rdy_d   = 1'b0;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (key_q == K_PAUSE) begin
          // Pause has no break sequence
          if (brk_q) begin
            rdy_d   = 1'b1;
            state_d = IDLE;
          end else begin
            pidx_d  = 3'd0;
            sc_d    = pause_byte(3'd0);
            scv_d   = 1'b1;
            state_d = PAUSE;
          end
        end else if (!lk[9]) begin
          rdy_d   = 1'b1;
          unm_d   = 1'b1;
          state_d = IDLE;
        end else begin
          code_d = lk[7:0];
          scv_d  = 1'b1;
          if (lk[8]) begin
            sc_d    = 8'hE0;
            state_d = SEND_E0;
          end else if (brk_q) begin
            sc_d    = 8'hF0;
            state_d = SEND_F0;
          end else begin
            sc_d    = lk[7:0];
            state_d = SEND_CODE;
          end
        end
      end
      SEND_E0: begin
        if (hs) begin
          if (brk_q) begin
            sc_d    = 8'hF0;
            state_d = SEND_F0;
          end else begin
            sc_d    = code_q;
            state_d = SEND_CODE;
          end
        end
      end
      SEND_F0: begin
        if (hs) begin
          sc_d    = code_q;
          state_d = SEND_CODE;
        end
      end
      SEND_CODE: begin
        if (hs) begin
          sc_d    = 8'h00;
          scv_d   = 1'b0;
          rdy_d   = 1'b1;
          state_d = IDLE;
        end
      end
      PAUSE: begin
        if (hs) begin
          if (pidx_q == 3'd7) begin
            pidx_d  = 3'd0;
            sc_d    = 8'h00;
            scv_d   = 1'b0;
            rdy_d   = 1'b1;
            state_d = IDLE;
          end else begin
            pidx_d = pidx_q + 3'd1;
            sc_d   = pause_byte(pidx_q + 3'd1);
          end
        end
      end
      default: begin
        sc_d    = 8'h00;
        scv_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      key_q      <= 7'd0;
      brk_q      <= 1'b0;
      code_q     <= 8'h00;
      pidx_q     <= 3'd0;
      scancode_o <= 8'h00;
      scvalid_o  <= 1'b0;
      kcready_o  <= 1'b0;
      unmapped_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      brk_q      <= brk_d;
      code_q     <= code_d;
      pidx_q     <= pidx_d;
      scancode_o <= sc_d;
      scvalid_o  <= scv_d;
      kcready_o  <= rdy_d;
      unmapped_o <= unm_d;
    end
  end

endmodule

// File: tb/tb_keycode_to_ps2_scancode.sv
// Directed bench for keycode_to_ps2_scancode: vector table
// plus hold-valid and reset-abort sequences.
module tb_keycode_to_ps2_scancode;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] keycode_i = 8'h00;
  logic       kcvalid_i = 1'b0;
  logic       kcready_o;
  logic [7:0] scancode_o;
  logic       scvalid_o;
  logic       scready_i = 1'b1;
  logic       unmapped_o;

  keycode_to_ps2_scancode dut (
    .clk        (clk),
    .reset      (reset),
    .keycode_i  (keycode_i),
    .kcvalid_i  (kcvalid_i),
    .kcready_o  (kcready_o),
    .scancode_o (scancode_o),
    .scvalid_o  (scvalid_o),
    .scready_i  (scready_i),
    .unmapped_o (unmapped_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  kc;
    int          n;
    logic [63:0] seq;
    bit          unm;
    int          mode;
  } vec_t;

  localparam logic [63:0] PSEQ = 64'hE11477E1F014F077;

  int vecs = 0;
  int errs = 0;
  vec_t vt[16];

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] want);
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  // mode 0: always ready, 1: 5-cycle stall per byte, 2: random
  task automatic run_key(input logic [7:0] kc, input int n,
                         input logic [63:0] seq, input bit unm,
                         input int mode);
    int got;
    int lat;
    int unm_cnt;
    int stall;
    bit held;
    bit done;
    logic [7:0] hold;
    logic [63:0] s;
    vecs++;
    s = seq;
    for (int i = 0; i < 20 && !kcready_o; i++) @(negedge clk);
    if (!kcready_o) begin
      errs++;
      $display("FAIL ready_wait kc=%h: kcready_o stuck 0", kc);
      return;
    end
    keycode_i = kc;
    kcvalid_i = 1'b1;
    scready_i = (mode == 0);
    @(posedge clk);
    #1;
    kcvalid_i = 1'b0;
    chk("busy_after_accept", kcready_o, 1'b0);
    got = 0; lat = 0; unm_cnt = 0; stall = 0;
    held = 0; done = 0; hold = 8'h00;
    for (int c = 1; c <= 300 && !done; c++) begin
      @(negedge clk);
      if (unmapped_o) unm_cnt++;
      if (kcready_o) begin
        lat = c;
        done = 1;
      end else begin
        if (held) chk("stall_stable", scancode_o, hold);
        case (mode)
          0: scready_i = 1'b1;
          1: begin
            if (scvalid_o && stall < 5) begin
              scready_i = 1'b0;
              stall++;
            end else begin
              scready_i = 1'b1;
              stall = 0;
            end
          end
          default: scready_i = 1'($urandom_range(0, 1));
        endcase
        held = scvalid_o && !scready_i;
        hold = scancode_o;
        if (scvalid_o && scready_i) begin
          if (got < 8) chk("byte", scancode_o, s[63-8*got -: 8]);
          got++;
        end
      end
    end
    if (!done) begin
      errs++;
      $display("FAIL timeout kc=%h: no return to ready", kc);
    end
    chk("byte_count", got, n);
    chk("unmapped_pulses", unm_cnt, 32'(unm));
    if (mode == 0 || n == 0) chk("ready_latency", lat, n + 2);
    scready_i = 1'b1;
  endtask

  function automatic int kn(input logic [7:0] kc);
    case (kc)
      8'h11:   return 1;
      8'h3D:   return 1;
      default: return 2;
    endcase
  endfunction

  function automatic logic [63:0] ks(input logic [7:0] kc);
    case (kc)
      8'h11:   return {8'h15, 56'h0};
      8'h3D:   return {8'h29, 56'h0};
      8'h54:   return {8'hE0, 8'h72, 48'h0};
      default: return {8'hF0, 8'h15, 48'h0};
    endcase
  endfunction

  initial begin
    logic [7:0] klist [4];
    logic [7:0] expq[$];
    logic [7:0] gotq[$];
    logic [63:0] sq;
    int next_free;

    vt[0]  = '{8'h11, 1, {8'h15, 56'h0}, 1'b0, 0};
    vt[1]  = '{8'h91, 2, {8'hF0, 8'h15, 48'h0}, 1'b0, 0};
    vt[2]  = '{8'h54, 2, {8'hE0, 8'h72, 48'h0}, 1'b0, 1};
    vt[3]  = '{8'hD4, 3, {24'hE0F072, 40'h0}, 1'b0, 1};
    vt[4]  = '{8'h7E, 8, PSEQ, 1'b0, 0};
    vt[5]  = '{8'hFE, 0, 64'h0, 1'b0, 0};
    vt[6]  = '{8'h00, 0, 64'h0, 1'b1, 0};
    vt[7]  = '{8'h7F, 0, 64'h0, 1'b1, 0};
    vt[8]  = '{8'h3D, 1, {8'h29, 56'h0}, 1'b0, 0};
    vt[9]  = '{8'hBB, 3, {24'hE0F01F, 40'h0}, 1'b0, 2};
    vt[10] = '{8'h7C, 2, {8'hE0, 8'h7C, 48'h0}, 1'b0, 0};
    vt[11] = '{8'h6E, 1, {8'h76, 56'h0}, 1'b0, 0};
    vt[12] = '{8'h6C, 2, {8'hE0, 8'h5A, 48'h0}, 1'b0, 0};
    vt[13] = '{8'hAB, 2, {8'hF0, 8'h5A, 48'h0}, 1'b0, 2};
    vt[14] = '{8'h0E, 0, 64'h0, 1'b1, 0};
    vt[15] = '{8'h7E, 8, PSEQ, 1'b0, 2};

    // reset state
    repeat (3) @(negedge clk);
    vecs++;
    chk("rst_kcready", kcready_o, 1'b0);
    chk("rst_scvalid", scvalid_o, 1'b0);
    chk("rst_scancode", scancode_o, 8'h00);
    chk("rst_unmapped", unmapped_o, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("rel_kcready", kcready_o, 1'b1);

    for (int i = 0; i < 16; i++)
      run_key(vt[i].kc, vt[i].n, vt[i].seq, vt[i].unm, vt[i].mode);

    // kcvalid_i held high with a changing key code
    vecs++;
    klist[0] = 8'h11;
    klist[1] = 8'h54;
    klist[2] = 8'h91;
    klist[3] = 8'h3D;
    scready_i = 1'b1;
    next_free = 0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      chk("hold_ready", kcready_o, 32'(c >= next_free));
      if (scvalid_o) gotq.push_back(scancode_o);
      keycode_i = klist[c % 4];
      kcvalid_i = (c < 30);
      if (c >= next_free && c < 30) begin
        sq = ks(klist[c % 4]);
        for (int b = 0; b < kn(klist[c % 4]); b++)
          expq.push_back(sq[63-8*b -: 8]);
        next_free = c + kn(klist[c % 4]) + 2;
      end
    end
    kcvalid_i = 1'b0;
    chk("hold_count", gotq.size(), expq.size());
    for (int b = 0; b < expq.size() && b < gotq.size(); b++)
      chk("hold_byte", gotq[b], expq[b]);

    // reset after the E0 of an ext break
    vecs++;
    @(negedge clk);
    keycode_i = 8'hD4;
    kcvalid_i = 1'b1;
    @(posedge clk);
    #1;
    kcvalid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_e0", scancode_o, 8'hE0);
    @(negedge clk);
    chk("abort_f0", scancode_o, 8'hF0);
    reset = 1'b1;
    #1;
    chk("abort_scvalid", scvalid_o, 1'b0);
    chk("abort_kcready", kcready_o, 1'b0);
    chk("abort_scancode", scancode_o, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_rel_ready", kcready_o, 1'b1);
    chk("abort_quiet", scvalid_o, 1'b0);
    run_key(8'h11, 1, {8'h15, 56'h0}, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
